// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the parametrised UART receiver and transmitter.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        LOAD      = 3'd5,
        WAIT_HIGH = 3'd6
    } rx_state_e;

    // Parity bit a transmitter appends; unused upper data bits must be zero.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Serial line plus valid/ready output handshake of the UART receiver.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 i_uart_rx;
    logic                 i_ready;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 o_parity_err;
    logic                 o_frame_err;
    logic                 o_overrun;
    logic                 o_busy;

    modport master (
        input  i_uart_rx, i_ready,
        output o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_busy
    );

    modport slave (
        output i_uart_rx, i_ready,
        input  o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// RX pin conditioning: 2-flop synchroniser, 3-sample majority window and the armed flag.
module uart_rx_sampler (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_line,
    output logic o_bit,
    output logic o_armed
);
    logic [1:0] sync_q;
    logic [1:0] known_q;
    logic [2:0] win_q;
    logic       armed_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q  <= '1;
            known_q <= '0;
            win_q   <= '1;
            armed_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbour.
            sync_q  <= {sync_q[0], i_rx};
            known_q <= {known_q[0], 1'b1};
            win_q   <= {win_q[1:0], sync_q[1]};
            // The preset 1s must flush out before a high line can arm the receiver.
            armed_q <= armed_q | (known_q[1] & sync_q[1]);
        end
    end

    assign o_line  = sync_q[1];
    assign o_bit   = (win_q[0] & win_q[1]) | (win_q[0] & win_q[2]) | (win_q[1] & win_q[2]);
    assign o_armed = armed_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable width/parity/stop bits, majority sampling,
// error flags and a valid/ready output register with sticky overrun.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input logic            i_clk,
    input logic            i_rst,
    uart_rx_param_if.master rx_if
);
    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int                IDX_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  HALF     = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    logic line, bit_maj, armed;

    uart_rx_sampler u_sampler (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_rx    (rx_if.i_uart_rx),
        .o_line  (line),
        .o_bit   (bit_maj),
        .o_armed (armed)
    );

    rx_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_q, ferr_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, perr_out_q, ferr_out_q, overrun_q, busy_q;

    logic tick, xfer;
    assign tick = (cnt_q == LAST);
    assign xfer = valid_q & rx_if.i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            // A LOAD below overrides this drop of valid, keeping the register full.
            if (xfer) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (armed && !line) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                end
                START: if (cnt_q == HALF) begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (bit_maj) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= DATA;
                    end
                end
                DATA: if (tick) begin
                    cnt_q          <= '0;
                    shift_q[idx_q] <= bit_maj;
                    if (idx_q == IDX_LAST) begin
                        state_q    <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                        stop_idx_q <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                uart_pkg::PARITY: if (tick) begin
                    cnt_q   <= '0;
                    perr_q  <= (bit_maj != parity_bit(9'(shift_q), PARITY));
                    state_q <= STOP;
                end
                STOP: if (tick) begin
                    cnt_q <= '0;
                    if (!bit_maj) ferr_q <= 1'b1;
                    if (stop_idx_q == STOP_LAST) state_q <= LOAD;
                    else                         stop_idx_q <= stop_idx_q + 1'b1;
                end
                LOAD: begin
                    if (!valid_q || rx_if.i_ready) begin
                        data_q     <= shift_q;
                        perr_out_q <= perr_q;
                        ferr_out_q <= ferr_q;
                        valid_q    <= 1'b1;
                    end else begin
                        overrun_q  <= 1'b1;
                    end
                    state_q <= ferr_q ? WAIT_HIGH : IDLE;
                    busy_q  <= ferr_q;
                end
                WAIT_HIGH: if (line) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.o_data       = data_q;
    assign rx_if.o_valid      = valid_q;
    assign rx_if.o_parity_err = perr_out_q;
    assign rx_if.o_frame_err  = ferr_out_q;
    assign rx_if.o_overrun    = overrun_q;
    assign rx_if.o_busy       = busy_q;

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised next-generation UART receiver for the loopback/serial designs. It replaces the fixed 8N1 receiver with configurable data width, parity and stop bits. It adds majority-vote bit sampling, false-start rejection, parity and framing error detection, and a valid/ready output register with overrun detection. The block sits between the FPGA RX pin and any consumer: the TX block, a FIFO, or the 7-segment display path.

Parameters:
CLKS_PER_BIT, 217, clocks per bit period; must be >= 8.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-high
i_uart_rx  in  1  asynchronous serial line; idle high
i_ready  in  1  consumer can accept o_data this cycle
o_data  out  DATA_BITS  received word, LSB = first bit on the wire
o_valid  out  1  o_data and the error flags are valid
o_parity_err  out  1  parity mismatch on the held frame; qualified by o_valid
o_frame_err  out  1  a stop bit sampled low on the held frame; qualified by o_valid
o_overrun  out  1  sticky: a completed frame was dropped because the output register was full
o_busy  out  1  high from start detection until return to IDLE

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; state IDLE.
  - Synchroniser flops and the 3-sample window preset to 1.
  - armed = 0.
- Input path: 2-flop synchroniser, then a 3-deep shift register. Bit value = majority of the 3 most recent synchronised samples.
- armed sets once the synchronised line is seen high. No start is accepted while armed = 0, so a line held low through reset is ignored.
- HALF = CLKS_PER_BIT/2 (integer division). The bit counter is $clog2(CLKS_PER_BIT) bits wide.
- State machine:
  - IDLE: when armed and the synchronised line is 0 → START, counter = 0, o_busy = 1.
  - START: at counter == HALF, evaluate the majority.
    - Majority 1 → IDLE (glitch rejected, nothing output).
    - Majority 0 → DATA, counter = 0, index = 0.
  - DATA: sample when counter == CLKS_PER_BIT-1 (the mid-point of each bit). Shift the sample into data[index], LSB first. After index DATA_BITS-1 → PARITY if PARITY != 0, else STOP.
  - PARITY: sample at CLKS_PER_BIT-1.
    - Expected bit = XOR of the data for even parity, its inverse for odd.
    - Mismatch sets a frame-local perr.
  - STOP: sample STOP_BITS times, each at CLKS_PER_BIT-1. Any low sample sets a frame-local ferr.
    - After the last stop sample → LOAD.
  - LOAD (one cycle): deliver the frame (see output register), then:
    - ferr = 0 → IDLE.
    - ferr = 1 → WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronised line is 1, then → IDLE. This handles break conditions without false restarts.
- Latency: o_valid rises 2 cycles after the final stop-bit sample cycle, plus the 2-cycle synchroniser delay relative to the pin.
- Output register:
  - On LOAD, if o_valid = 0, or o_valid && i_ready in the same cycle:
    - Load o_data, o_parity_err and o_frame_err.
    - o_valid = 1 next cycle.
  - On LOAD with o_valid = 1 and i_ready = 0:
    - The new frame is discarded and o_overrun set to 1.
    - Held data and flags are unchanged.
  - Transfer: o_valid && i_ready at a clock edge. o_valid drops next cycle unless a LOAD coincides, in which case o_valid stays 1 with the new data.
  - o_overrun clears on the next transfer, or on reset.
  - A frame with errors is still delivered, flagged.
- Reset mid-frame: immediate return to IDLE with all outputs 0. Any partial frame is lost and never delivered.

Decomposition:
- Package uart_pkg:
  - Parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - State encoding localparams IDLE, START, DATA, PARITY, STOP, LOAD, WAIT_HIGH.
  - Shared with the planned parametrised TX.
- One sub-module, uart_rx_sampler: 2-flop synchroniser, 3-sample window, majority output and armed flag, with async reset presetting to 1.

Test Plan:
- 8N1, CLKS_PER_BIT=16, i_ready=1, send 0xA5 → one o_valid pulse, o_data=0xA5, both error flags 0, o_overrun=0.
- PARITY=2, send 0x03 with parity bit 1 (expected 0) → o_valid, o_data=0x03, o_parity_err=1. Repeat with parity bit 0 → o_parity_err=0.
- Drive the line low for 4 cycles then high; CLKS_PER_BIT=16 → no o_valid, o_busy returns to 0. Then send 0x5A → o_data=0x5A.
- Send 0x3C with the stop bit held low for 3 bit times → o_frame_err=1, o_data=0x3C. No further o_valid until the line has returned high and a new frame 0x81 is sent, giving o_data=0x81.
- i_ready=0, send 0x11 then 0x22 → o_data stays 0x11, o_overrun=1. Then i_ready=1 for one cycle → transfer of 0x11, o_valid=0, o_overrun=0.
- DATA_BITS=7, STOP_BITS=2: assert i_rst during data bit 3 → all outputs 0 immediately, no o_valid for that frame. After release, send 0x7E → o_data=0x7E.
